// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the pipeline hazard detection unit:
//   - state_e      : stall sequencer states (ST_RUN, ST_STALL)
//   - need_t       : requested stall length (STALL_NONE / STALL_ONE / STALL_TWO)
//   - reg_match()  : does a producer destination feed a source of the ID instr
// -----------------------------------------------------------------------------
package hazard_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_e;

    localparam int NEED_W = 2;
    typedef logic [NEED_W-1:0] need_t;

    localparam need_t STALL_NONE = 2'd0;
    localparam need_t STALL_ONE  = 2'd1;
    localparam need_t STALL_TWO  = 2'd2;

    // $0 is hardwired to zero, so a write to it can never create a dependency.
    function automatic logic reg_match(input logic [4:0] dst,
                                       input logic [4:0] rs,
                                       input logic [4:0] rt,
                                       input logic       uses_rt);
        return (dst != 5'd0) && ((dst == rs) || (uses_rt && (dst == rt)));
    endfunction

endpackage

// File: rtl/perf_counter.sv
// -----------------------------------------------------------------------------
// perf_counter
// Free-running event counter, wraps modulo 2^CNT_W.
// Ports:
//   clk    in   pipeline clock
//   reset  in   synchronous active-high clear
//   en     in   count this cycle
//   count  out  current count (CNT_W bits)
// -----------------------------------------------------------------------------
module perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/hazard_detection_unit.sv
// -----------------------------------------------------------------------------
// hazard_detection_unit
// Stall/flush generator for the 5-stage MIPS pipeline. Detects load-use and
// branch-in-ID operand hazards, sequences 1- or 2-cycle stalls, flushes IF/ID
// on a taken branch or jump resolved in ID, and counts stalls and flushes.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   if_id_rs/rt/uses_rt         source registers of the ID instruction
//   if_id_branch/jump           ID instruction is beq/bne or j/jal/jr
//   branch_taken                ID comparator result (only with if_id_branch)
//   id_ex_memread/regwrite/dst  EX-stage producer info
//   ex_mem_memread/dst          MEM-stage producer info
//   pc_write, if_id_write       pipeline front-end enables
//   id_ex_bubble                insert nop into ID/EX
//   if_id_flush                 clear IF/ID on the next edge
//   stall_cycles, flush_count   performance counters
// -----------------------------------------------------------------------------
module hazard_detection_unit
    import hazard_pkg::*;
#(
    parameter int CNT_W     = 32,
    parameter int MAX_STALL = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       if_id_rs,
    input  logic [4:0]       if_id_rt,
    input  logic             if_id_uses_rt,
    input  logic             if_id_branch,
    input  logic             if_id_jump,
    input  logic             branch_taken,
    input  logic             id_ex_memread,
    input  logic             id_ex_regwrite,
    input  logic [4:0]       id_ex_dst,
    input  logic             ex_mem_memread,
    input  logic [4:0]       ex_mem_dst,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    // rem only has to hold the cycles remaining after the first stall cycle.
    localparam int REM_W = (MAX_STALL > 2) ? $clog2(MAX_STALL) : 1;

    state_e           state_q, state_d;
    logic [REM_W-1:0] rem_q, rem_d;

    need_t need;
    logic  match_ex;
    logic  match_mem;
    logic  stall;

    // Required stall length: maximum over all applicable hazard rules.
    always_comb begin
        match_ex  = reg_match(id_ex_dst,  if_id_rs, if_id_rt, if_id_uses_rt);
        match_mem = reg_match(ex_mem_dst, if_id_rs, if_id_rt, if_id_uses_rt);
        need      = STALL_NONE;
        if (id_ex_memread && match_ex) begin
            need = STALL_ONE;
        end
        if (if_id_branch && id_ex_regwrite && !id_ex_memread && match_ex) begin
            need = STALL_ONE;
        end
        if (if_id_branch && ex_mem_memread && match_mem) begin
            need = STALL_ONE;
        end
        // A branch waiting on a load in EX needs the load to reach WB-forwarding
        // range, which is two cycles away.
        if (if_id_branch && id_ex_memread && match_ex) begin
            need = STALL_TWO;
        end
    end

    // Next-state logic. One-cycle stalls stay in RUN and simply re-evaluate;
    // only longer stalls need the STALL state and its down-counter.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        unique case (state_q)
            ST_RUN: begin
                if (need > STALL_ONE) begin
                    state_d = ST_STALL;
                    rem_d   = REM_W'(need - STALL_ONE);
                end
            end
            ST_STALL: begin
                rem_d = rem_q - REM_W'(1);
                if (rem_q <= REM_W'(1)) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
                rem_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    // Output decode. Stall is Mealy so it acts in the detection cycle, and it
    // overrides any flush because branch operands are not valid during a stall.
    always_comb begin
        stall        = ((state_q == ST_RUN) && (need != STALL_NONE)) ||
                       (state_q == ST_STALL);
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        if (reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end else if (stall) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end else begin
            if_id_flush  = (if_id_branch && branch_taken) || if_id_jump;
        end
    end

    perf_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (stall && !reset),
        .count (stall_cycles)
    );

    perf_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (if_id_flush),
        .count (flush_count)
    );

endmodule

// File: tb/tb_hazard_detection_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_detection_unit
// Directed bench for hazard_detection_unit. Inputs change on the falling edge;
// outputs are sampled 1 time unit later, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_hazard_detection_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  if_id_rs, if_id_rt;
    logic        if_id_uses_rt, if_id_branch, if_id_jump, branch_taken;
    logic        id_ex_memread, id_ex_regwrite;
    logic [4:0]  id_ex_dst;
    logic        ex_mem_memread;
    logic [4:0]  ex_mem_dst;
    logic        pc_write, if_id_write, id_ex_bubble, if_id_flush;
    logic [31:0] stall_cycles, flush_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_detection_unit #(.CNT_W(32), .MAX_STALL(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .if_id_rs       (if_id_rs),
        .if_id_rt       (if_id_rt),
        .if_id_uses_rt  (if_id_uses_rt),
        .if_id_branch   (if_id_branch),
        .if_id_jump     (if_id_jump),
        .branch_taken   (branch_taken),
        .id_ex_memread  (id_ex_memread),
        .id_ex_regwrite (id_ex_regwrite),
        .id_ex_dst      (id_ex_dst),
        .ex_mem_memread (ex_mem_memread),
        .ex_mem_dst     (ex_mem_dst),
        .pc_write       (pc_write),
        .if_id_write    (if_id_write),
        .id_ex_bubble   (id_ex_bubble),
        .if_id_flush    (if_id_flush),
        .stall_cycles   (stall_cycles),
        .flush_count    (flush_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check the four control outputs: {pc_write, if_id_write, id_ex_bubble, if_id_flush}
    task automatic chk_ctl(input string tag, input logic [3:0] exp);
        chk(tag, {28'd0, pc_write, if_id_write, id_ex_bubble, if_id_flush}, {28'd0, exp});
    endtask

    // Advance to the next falling edge and return all inputs to an idle pipeline.
    task automatic idle_step();
        @(negedge clk);
        if_id_rs       = 5'd0;  if_id_rt     = 5'd0;
        if_id_uses_rt  = 1'b0;  if_id_branch = 1'b0;
        if_id_jump     = 1'b0;  branch_taken = 1'b0;
        id_ex_memread  = 1'b0;  id_ex_regwrite = 1'b0; id_ex_dst = 5'd0;
        ex_mem_memread = 1'b0;  ex_mem_dst   = 5'd0;
    endtask

    localparam logic [3:0] RUN_CTL   = 4'b1100;
    localparam logic [3:0] STALL_CTL = 4'b0010;
    localparam logic [3:0] FLUSH_CTL = 4'b1101;

    initial begin
        reset = 1'b1;
        idle_step();
        idle_step();
        #1;
        chk_ctl("reset_outputs", STALL_CTL);
        chk("reset_stall_cnt", stall_cycles, 32'd0);
        chk("reset_flush_cnt", flush_count, 32'd0);

        // Load-use: lw $8 in EX, add $9,$8,$10 in ID
        idle_step(); reset = 1'b0;
        id_ex_memread = 1'b1; id_ex_dst = 5'd8;
        if_id_rs = 5'd8; if_id_rt = 5'd10; if_id_uses_rt = 1'b1;
        #1 chk_ctl("loaduse_stall", STALL_CTL);
        idle_step();
        if_id_rs = 5'd8; if_id_rt = 5'd10; if_id_uses_rt = 1'b1;
        #1 chk_ctl("loaduse_resume", RUN_CTL);
        chk("loaduse_cnt", stall_cycles, 32'd1);

        // Branch after load: lw $8 in EX, beq $8,$9 in ID -> two stall cycles
        idle_step();
        id_ex_memread = 1'b1; id_ex_dst = 5'd8;
        if_id_rs = 5'd8; if_id_rt = 5'd9; if_id_uses_rt = 1'b1; if_id_branch = 1'b1;
        #1 chk_ctl("brload_stall1", STALL_CTL);
        idle_step();
        if_id_rs = 5'd8; if_id_rt = 5'd9; if_id_uses_rt = 1'b1; if_id_branch = 1'b1;
        #1 chk_ctl("brload_stall2", STALL_CTL);
        idle_step();
        if_id_rs = 5'd8; if_id_rt = 5'd9; if_id_uses_rt = 1'b1; if_id_branch = 1'b1;
        #1 chk_ctl("brload_resume", RUN_CTL);
        chk("brload_cnt", stall_cycles, 32'd3);

        // Branch after ALU op: add $8 in EX, beq $8,$0 in ID, then taken
        idle_step();
        id_ex_regwrite = 1'b1; id_ex_dst = 5'd8;
        if_id_rs = 5'd8; if_id_rt = 5'd0; if_id_uses_rt = 1'b1; if_id_branch = 1'b1;
        #1 chk_ctl("bralu_stall", STALL_CTL);
        idle_step();
        if_id_rs = 5'd8; if_id_uses_rt = 1'b1; if_id_branch = 1'b1; branch_taken = 1'b1;
        #1 chk_ctl("bralu_flush", FLUSH_CTL);
        chk("bralu_stall_cnt", stall_cycles, 32'd4);
        idle_step();
        #1 chk("bralu_flush_cnt", flush_count, 32'd1);

        // No hazard: load into $0 with $0 sources
        idle_step();
        id_ex_memread = 1'b1; id_ex_dst = 5'd0; if_id_uses_rt = 1'b1;
        #1 chk_ctl("dst_zero", RUN_CTL);
        // rt matches but the instruction does not read rt
        idle_step();
        id_ex_memread = 1'b1; id_ex_dst = 5'd5;
        if_id_rs = 5'd6; if_id_rt = 5'd5; if_id_uses_rt = 1'b0;
        #1 chk_ctl("rt_unused", RUN_CTL);
        // Load in MEM only matters for branches
        idle_step();
        ex_mem_memread = 1'b1; ex_mem_dst = 5'd7; if_id_rs = 5'd7;
        #1 chk_ctl("memload_nonbranch", RUN_CTL);
        // Jump in ID flushes for exactly one cycle
        idle_step();
        if_id_jump = 1'b1;
        #1 chk_ctl("jump_flush", FLUSH_CTL);
        idle_step();
        #1 chk_ctl("jump_done", RUN_CTL);
        chk("nohaz_stall_cnt", stall_cycles, 32'd4);
        chk("jump_flush_cnt", flush_count, 32'd2);

        // Stall beats flush: taken branch during STALL is ignored
        idle_step();
        id_ex_memread = 1'b1; id_ex_dst = 5'd8;
        if_id_rs = 5'd9; if_id_rt = 5'd8; if_id_uses_rt = 1'b1; if_id_branch = 1'b1;
        branch_taken = 1'b1;
        #1 chk_ctl("prio_stall1", STALL_CTL);
        idle_step();
        if_id_rs = 5'd9; if_id_rt = 5'd8; if_id_uses_rt = 1'b1; if_id_branch = 1'b1;
        branch_taken = 1'b1;
        #1 chk_ctl("prio_stall2_noflush", STALL_CTL);
        idle_step();
        if_id_rs = 5'd9; if_id_rt = 5'd8; if_id_uses_rt = 1'b1; if_id_branch = 1'b1;
        branch_taken = 1'b1;
        #1 chk_ctl("prio_flush_after", FLUSH_CTL);
        idle_step();
        #1 chk("prio_stall_cnt", stall_cycles, 32'd6);
        chk("prio_flush_cnt", flush_count, 32'd3);

        // Branch with a load in MEM: one stall cycle
        idle_step();
        ex_mem_memread = 1'b1; ex_mem_dst = 5'd7;
        if_id_rs = 5'd7; if_id_branch = 1'b1;
        #1 chk_ctl("brmem_stall", STALL_CTL);
        idle_step();
        #1 chk("brmem_cnt", stall_cycles, 32'd7);

        // Reset in the middle of a STALL
        idle_step();
        id_ex_memread = 1'b1; id_ex_dst = 5'd8;
        if_id_rs = 5'd8; if_id_branch = 1'b1;
        #1 chk_ctl("rststall_enter", STALL_CTL);
        idle_step();
        reset = 1'b1;
        #1 chk_ctl("rststall_forced", STALL_CTL);
        idle_step();
        #1 chk_ctl("rststall_held", STALL_CTL);
        chk("rststall_stall_cnt", stall_cycles, 32'd0);
        chk("rststall_flush_cnt", flush_count, 32'd0);
        idle_step();
        reset = 1'b0;
        #1 chk_ctl("rststall_released", RUN_CTL);
        idle_step();
        #1 chk("rststall_no_residual", stall_cycles, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
